// File: rtl/idli_uart_tx_m_if.sv
// Nibble handshake from the core plus the serial line and busy status of the UART transmitter.
interface idli_uart_tx_m_if;
  logic [3:0] i_utx_data;
  logic       i_utx_data_vld;
  logic       o_utx_data_acp;
  logic       o_utx_tx;
  logic       o_utx_busy;

  modport master (
    output i_utx_data, i_utx_data_vld,
    input  o_utx_data_acp, o_utx_tx, o_utx_busy
  );

  modport slave (
    input  i_utx_data, i_utx_data_vld,
    output o_utx_data_acp, o_utx_tx, o_utx_busy
  );
endinterface

// File: rtl/idli_uart_tx_m.sv
// Packs core nibbles (low first) into bytes and sends them as 8N1 frames; start bit begins two cycles after
// the high nibble is accepted. The core is back-pressured only while the one-byte holding register is full.
module idli_uart_tx_m #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             i_utx_gck,
  input  logic             i_utx_rst,
  idli_uart_tx_m_if.slave  utx
);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [1:0]      hold_cnt_q, hold_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic            acp;
  logic            baud_end;
  logic            load;

  always_ff @(posedge i_utx_gck) begin
    if (i_utx_rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      shift_q    <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      shift_q    <= shift_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    shift_d    = shift_q;
    baud_d     = baud_q;
    bit_d      = bit_q;

    acp      = utx.i_utx_data_vld && (hold_cnt_q != 2'd2);
    baud_end = (baud_q == BAUD_LAST);
    load     = (hold_cnt_q == 2'd2) &&
               ((state_q == IDLE) || ((state_q == STOP) && baud_end));

    if (acp) begin
      if (hold_cnt_q == 2'd0) hold_d[3:0] = utx.i_utx_data;
      else                    hold_d[7:4] = utx.i_utx_data;
      hold_cnt_d = hold_cnt_q + 2'd1;
    end

    case (state_q)
      IDLE: baud_d = '0;
      START: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A load only happens with the hold full, so it never collides with a nibble accept.
    if (load) begin
      shift_d    = hold_q;
      hold_cnt_d = 2'd0;
      baud_d     = '0;
      state_d    = START;
    end
  end

  assign utx.o_utx_data_acp = acp;
  assign utx.o_utx_busy     = (state_q != IDLE) || (hold_cnt_q != 2'd0);
  assign utx.o_utx_tx       = (state_q == START) ? 1'b0 :
                              (state_q == DATA)  ? shift_q[0] : 1'b1;
endmodule

// File: tb/tb_idli_uart_tx_m.sv
// Bench for idli_uart_tx_m at 4 clocks per bit: per-cycle vector table for one frame, then directed sequences.
module tb_idli_uart_tx_m;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  idli_uart_tx_m_if uif();

  idli_uart_tx_m #(.CLKS_PER_BIT(4)) dut (
    .i_utx_gck (clk),
    .i_utx_rst (rst),
    .utx       (uif.slave)
  );

  typedef struct {
    logic       rst;
    logic [3:0] data;
    logic       vld;
    logic       acp;
    logic       tx;
    logic       busy;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;

  logic [7:0] rx_bytes[$];
  int         rx_start[$];
  logic       rx_act = 1'b0;
  int         rx_ph  = 0;
  logic [7:0] rx_sh  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Line receiver: samples mid-bit, counting from the first low cycle of the start bit.
  always @(posedge clk) begin
    if (uif.o_utx_data_acp && dut.hold_cnt_q == 2'd2) viol++;
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (uif.o_utx_tx == 1'b0) begin
        rx_act = 1'b1;
        rx_ph  = 0;
        rx_start.push_back(cyc);
      end
    end else begin
      rx_ph++;
      if (rx_ph == 2) chk("rx_start_bit", {31'd0, uif.o_utx_tx}, 32'd0);
      if (rx_ph >= 6 && rx_ph <= 34 && (rx_ph % 4) == 2) rx_sh = {uif.o_utx_tx, rx_sh[7:1]};
      if (rx_ph == 38) begin
        chk("rx_stop_bit", {31'd0, uif.o_utx_tx}, 32'd1);
        rx_bytes.push_back(rx_sh);
        rx_act = 1'b0;
      end
    end
    cyc = cyc + 1;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] d, output int acc_cyc);
    acc_cyc = -1;
    uif.i_utx_data     = d;
    uif.i_utx_data_vld = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      #1;
      if (uif.o_utx_data_acp) begin
        acc_cyc = cyc;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int t = 0; t < budget && rx_bytes.size() < n; t++) @(negedge clk);
    chk("rx_byte_count", rx_bytes.size(), n);
  endtask

  vec_t       vecs[$];
  vec_t       v;
  logic [7:0] frame_byte;
  int         acc[$];
  int         a, t0, bad_tx, bad_busy, nib_exp_q[$];
  logic [7:0] exp_bytes[$];
  int         acc_rel[6] = '{0, 1, 3, 4, 43, 44};
  int         start_rel[3] = '{3, 43, 83};

  initial begin
    uif.i_utx_data     = 4'h0;
    uif.i_utx_data_vld = 1'b0;

    // ---- single byte 0xA5 as a per-cycle table ----
    frame_byte = 8'hA5;
    v = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0}; vecs.push_back(v);  // reset held
    v = '{1'b0, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0}; vecs.push_back(v);  // low nibble
    v = '{1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1}; vecs.push_back(v);  // high nibble
    v = '{1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1}; vecs.push_back(v);  // load cycle, hold full
    for (int k = 0; k < 4; k++) begin
      v = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}; vecs.push_back(v);
    end
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 4; k++) begin
        v = '{1'b0, 4'h0, 1'b0, 1'b0, frame_byte[b], 1'b1}; vecs.push_back(v);
      end
    for (int k = 0; k < 4; k++) begin
      v = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1}; vecs.push_back(v);
    end
    for (int k = 0; k < 2; k++) begin
      v = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0}; vecs.push_back(v);
    end

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst                = vecs[i].rst;
      uif.i_utx_data     = vecs[i].data;
      uif.i_utx_data_vld = vecs[i].vld;
      #1;
      if (uif.o_utx_data_acp !== vecs[i].acp || uif.o_utx_tx !== vecs[i].tx || uif.o_utx_busy !== vecs[i].busy) begin
        $display("FAIL vec[%0d]: acp/tx/busy=%b%b%b expected %b%b%b", i,
                 uif.o_utx_data_acp, uif.o_utx_tx, uif.o_utx_busy, vecs[i].acp, vecs[i].tx, vecs[i].busy);
        bad++;
      end
      total++;
      @(negedge clk);
    end
    chk("single_rx_count", rx_bytes.size(), 1);
    if (rx_bytes.size() > 0) chk("single_rx_byte", rx_bytes[0], 8'hA5);

    // ---- back-to-back 0x00, 0xFF, 0x3C with vld held high ----
    rx_bytes.delete(); rx_start.delete();
    send_nib(4'h0, a); acc.push_back(a);
    send_nib(4'h0, a); acc.push_back(a);
    send_nib(4'hF, a); acc.push_back(a);
    send_nib(4'hF, a); acc.push_back(a);
    send_nib(4'hC, a); acc.push_back(a);
    send_nib(4'h3, a); acc.push_back(a);
    uif.i_utx_data_vld = 1'b0;
    wait_bytes(3, 400);
    t0 = acc[0];
    for (int i = 1; i < 6; i++) chk($sformatf("b2b_accept_%0d", i), acc[i] - t0, acc_rel[i]);
    for (int i = 0; i < 3; i++)
      if (rx_start.size() > i) chk($sformatf("b2b_start_%0d", i), rx_start[i] - t0, start_rel[i]);
    if (rx_bytes.size() == 3) begin
      chk("b2b_byte0", rx_bytes[0], 8'h00);
      chk("b2b_byte1", rx_bytes[1], 8'hFF);
      chk("b2b_byte2", rx_bytes[2], 8'h3C);
    end
    idle(4);
    chk("b2b_busy_after", uif.o_utx_busy, 1'b0);

    // ---- lone nibble waits, then completes as 0x17 ----
    rx_bytes.delete();
    send_nib(4'h7, a);
    uif.i_utx_data_vld = 1'b0;
    bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (uif.o_utx_tx !== 1'b1) bad_tx++;
      if (uif.o_utx_busy !== 1'b1) bad_busy++;
      @(negedge clk);
    end
    chk("lone_tx_high_cycles_bad", bad_tx, 0);
    chk("lone_busy_low_cycles_bad", bad_busy, 0);
    chk("lone_hold_cnt", dut.hold_cnt_q, 2'd1);
    send_nib(4'h1, a);
    uif.i_utx_data_vld = 1'b0;
    wait_bytes(1, 100);
    if (rx_bytes.size() == 1) chk("lone_byte", rx_bytes[0], 8'h17);
    idle(4);

    // ---- reset during data bit 3 with a second byte held ----
    rx_bytes.delete(); rx_start.delete();
    send_nib(4'h6, a);
    send_nib(4'h9, a);
    send_nib(4'h1, a);
    send_nib(4'h2, a);
    uif.i_utx_data_vld = 1'b0;
    for (int t = 0; t < 100 && !(rx_start.size() > 0 && cyc >= rx_start[0] + 17); t++) @(negedge clk);
    chk("rst_frame_started", rx_start.size(), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_tx", uif.o_utx_tx, 1'b1);
    chk("rst_mid_busy", uif.o_utx_busy, 1'b0);
    @(negedge clk);
    bad_tx = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (uif.o_utx_tx !== 1'b1) bad_tx++;
      @(negedge clk);
    end
    chk("rst_no_more_frames_tx", bad_tx, 0);
    chk("rst_no_bytes", rx_bytes.size(), 0);

    // ---- sporadic vld across 50 bytes ----
    rx_bytes.delete();
    for (int i = 0; i < 50; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 50; i++) begin
      frame_byte = exp_bytes[i];
      uif.i_utx_data_vld = 1'b0;
      idle($urandom_range(0, 30));
      send_nib(frame_byte[3:0], a);
      uif.i_utx_data_vld = 1'b0;
      idle($urandom_range(0, 30));
      send_nib(frame_byte[7:4], a);
    end
    uif.i_utx_data_vld = 1'b0;
    wait_bytes(50, 3000);
    for (int i = 0; i < 50 && i < rx_bytes.size(); i++)
      chk($sformatf("spor_byte_%0d", i), rx_bytes[i], exp_bytes[i]);
    chk("acp_while_full", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
